// File: rtl/crc32_engine.sv
// Byte-serial CRC-32 core: MSB-first, non-reflected. It folds 1, 2 or 4 bytes of an
// MSB-aligned word into the running CRC, one byte per clock.
module crc32_engine #(
   parameter logic [31:0] POLY   = 32'h04C11DB7,
   parameter logic [31:0] INIT   = 32'hFFFFFFFF,
   parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_size,
   output logic        busy,
   output logic        done,
   output logic [31:0] crc_state,
   output logic [31:0] crc_out
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [31:0] shift_q, shift_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
      return c;
   endfunction

   function automatic logic [2:0] size_to_cnt(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      crc_d    = crc_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      in_ready = (state_q == IDLE) && !clear && !rst;
      case (state_q)
         IDLE: begin
            if (clear) begin
               crc_d = INIT;
            end else if (in_valid && in_ready) begin
               shift_d = in_data;
               cnt_d   = size_to_cnt(in_size);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // clear beats the final byte: abort without a done pulse
            if (clear) begin
               crc_d   = INIT;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               crc_d   = crc_byte(crc_q, shift_q[31:24]);
               shift_d = {shift_q[23:0], 8'h00};
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= INIT;
         cnt_q   <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // The byte shifter is pure datapath; it is only read while the counter is live.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign busy      = (state_q == SHIFT);
   assign done      = done_q;
   assign crc_state = crc_q;
   assign crc_out   = crc_q ^ XOROUT;

endmodule

// File: tb/tb_crc32_engine.sv
// Scoreboard bench for crc32_engine: drivers queue expected CRC and busy length per word,
// and a monitor checks them on every done pulse.
module tb_crc32_engine;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic [1:0]  in_size = 2'b00;
   logic        busy;
   logic        done;
   logic [31:0] crc_state;
   logic [31:0] crc_out;

   crc32_engine dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_size(in_size), .busy(busy), .done(done),
      .crc_state(crc_state), .crc_out(crc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] crc;
      int          n;
   } exp_t;

   exp_t        sbq[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          busy_run = 0;
   logic [31:0] ref_crc = INIT;

   // Reference: XOR the byte into the top of the register, then shift 8 times.
   function automatic logic [31:0] ref_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {b, 24'h0};
      for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      return r;
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] c, input logic [31:0] d,
                                            input logic [1:0] sz);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < nbytes(sz); i++) r = ref_byte(r, d[31-8*i -: 8]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] d, input logic [1:0] sz);
      int  k;
      bit  ok;
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_size  = sz;
      ok = 1'b0;
      k  = 0;
      while (!ok && k < 40) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         k++;
      end
      if (!ok) begin
         chk("send_accept_timeout", 32'd0, 32'd1);
      end else begin
         ref_crc = ref_word(ref_crc, d, sz);
         e.crc = ref_crc;
         e.n   = nbytes(sz);
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 32'hDEADBEEF;
      in_size  = 2'b10;
   endtask

   // Returns at posedge+1 after the done cycle.
   task automatic wait_done();
      int k;
      bit seen;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         k++;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      ref_crc = INIT;
   endtask

   task automatic check_string(input logic [1:0] wide_sz, input string tag);
      int d0;
      d0 = done_cnt;
      send(32'h31323334, wide_sz);
      send(32'h35363738, wide_sz);
      send(32'h39000000, 2'b00);
      wait_done();
      chk({tag, "_state"}, crc_state, 32'h0376E6E7);
      chk({tag, "_out"}, crc_out, 32'hFC891918);
      chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd3);
   endtask

   initial begin
      int          pend;
      int          lowrun;
      logic [31:0] bpd;
      exp_t        e;

      fork
         forever begin
            @(negedge clk);
            if (done) begin
               done_cnt++;
               if (sbq.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("sb_crc_state", crc_state, e.crc);
                  chk("sb_crc_out", crc_out, ~e.crc);
                  chk("sb_busy_len", 32'(busy_run), 32'(e.n));
                  chk("sb_done_ready", {31'b0, in_ready}, 32'd1);
                  chk("sb_done_busy", {31'b0, busy}, 32'd0);
               end
               busy_run = 0;
            end else if (busy) begin
               busy_run++;
            end else begin
               busy_run = 0;
            end
         end
      join_none

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_state", crc_state, 32'hFFFFFFFF);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_state", crc_state, 32'hFFFFFFFF);
      chk("idle_out", crc_out, 32'h00000000);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;

      check_string(2'b10, "chk4");

      // 2-byte words with garbage in the low half
      do_clear();
      send(32'h3132A5A5, 2'b01);
      send(32'h33345A5A, 2'b01);
      send(32'h3536FFFF, 2'b01);
      send(32'h37381234, 2'b01);
      send(32'h39C3C3C3, 2'b00);
      wait_done();
      chk("size2_out", crc_out, 32'hFC891918);

      do_clear();
      check_string(2'b11, "chk11");

      // Clear in the second SHIFT cycle
      do_clear();
      in_valid = 1'b1;
      in_data  = 32'h31323334;
      in_size  = 2'b10;
      @(negedge clk);
      chk("abort_accept_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      chk("abort_state", crc_state, 32'hFFFFFFFF);
      chk("abort_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      chk("abort_done2", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      ref_crc = INIT;
      check_string(2'b10, "rerun");

      // Clear and valid together in IDLE
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h41424344;
      in_size  = 2'b10;
      @(negedge clk);
      chk("coll_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      ref_crc  = INIT;
      @(negedge clk);
      chk("coll_busy", {31'b0, busy}, 32'd0);
      chk("coll_state", crc_state, INIT);
      @(negedge clk);
      chk("coll_busy2", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;

      // Backpressure: valid held high, data changes every cycle
      pend   = 0;
      lowrun = 0;
      for (int c = 0; c < 40; c++) begin
         bpd      = 32'h9E3779B9 * 32'(c + 1);
         in_valid = 1'b1;
         in_data  = bpd;
         in_size  = 2'(c % 4);
         @(negedge clk);
         if (in_ready) begin
            if (pend > 0) chk("bp_ready_low", 32'(lowrun), 32'(pend));
            ref_crc = ref_word(ref_crc, bpd, 2'(c % 4));
            e.crc = ref_crc;
            e.n   = nbytes(2'(c % 4));
            sbq.push_back(e);
            pend   = e.n;
            lowrun = 0;
         end else begin
            lowrun++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
      chk("bp_drain", 32'(sbq.size()), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-word
      in_valid = 1'b1;
      in_data  = 32'h11223344;
      in_size  = 2'b10;
      @(negedge clk);
      chk("arst_accept_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_ready", {31'b0, in_ready}, 32'd0);
      chk("arst_state", crc_state, INIT);
      chk("arst_out", crc_out, 32'h00000000);
      chk("arst_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      chk("final_queue", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/crc32_engine.md
# crc32_engine

Sequential CRC-32 core for the CRC32 peripheral. It consumes 32-bit words after the input bit-reversal stage, which performs any input reflection, and folds 1, 2 or 4 bytes per word into the running CRC at one byte per clock. The register interface reads the result through the output bit-reversal stage. The core is MSB-first and non-reflected; reflection is handled outside it.

## Interface
- POLY, 32'h04C11DB7, generator polynomial (implicit x^32).
- INIT, 32'hFFFFFFFF, value loaded on reset and on clear.
- XOROUT, 32'hFFFFFFFF, XOR applied to crc_state to form crc_out.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous reload of INIT; aborts any word in progress.
- in_valid  input  1  in_data/in_size presented.
- in_ready  output  1  core can accept a word this cycle.
- in_data  input  32  payload, MSB-aligned: first byte in [31:24].
- in_size  input  2  00=1 byte, 01=2 bytes, 10=4 bytes, 11 treated as 4 bytes.
- busy  output  1  word in progress.
- done  output  1  one-cycle pulse after the last byte of a word is folded in.
- crc_state  output  32  raw running CRC register.
- crc_out  output  32  crc_state ^ XOROUT, combinational.

## Operation
- State machine:
  - IDLE:
    - in_ready = !clear.
    - An accept occurs when in_valid && in_ready. It latches in_data into a 32-bit shift register and sets the byte counter to 1, 2 or 4 from in_size. The machine then moves to SHIFT.
  - SHIFT, one byte per cycle:
    - crc_state advances by 8 MSB-first LFSR steps using shift[31:24]: for each bit, fb = crc[31] ^ d, crc = (crc << 1) ^ (fb ? POLY : 0).
    - The shift register shifts left 8 and the counter decrements.
    - When the counter reaches 1, the next state is IDLE and done is registered high.
- busy = (state == SHIFT). in_ready is 0 throughout SHIFT; there is no input buffering.
- clear:
  - In IDLE: crc_state <= INIT, and no word is accepted that cycle.
  - In SHIFT: abort, crc_state <= INIT, state <= IDLE, counter <= 0, no done pulse.
  - clear wins over in_valid and over a final byte in the same cycle.
- Multiple words chain: crc_state is never reloaded between words, only by clear or rst.
- in_data and in_size are ignored when not accepted and need not stay stable after acceptance.
- Reset values: state=IDLE, crc_state=INIT, crc_out=INIT^XOROUT, busy=0, done=0, in_ready=0 while rst is high.

## Timing
- The accept happens at edge E.
- crc_state updates at edges E+1 … E+N, where N = 1, 2 or 4 bytes.
- done is high during the cycle following edge E+N, together with in_ready=1 and busy=0.
- Back-to-back: the next accept is possible at edge E+N+1.
- Sustained throughput: N bytes per N+1 cycles.
- crc_state and crc_out are valid in the done cycle and stay stable in IDLE until the next accept or clear.
- done never asserts in the same cycle as an accept.
- An rst assertion mid-word returns all outputs to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then idle:
  - Hold rst for 3 cycles, then release.
  - Required: crc_state=0xFFFFFFFF, crc_out=0x00000000, busy=0, done=0, and in_ready=1 from the first cycle after release.
- Check string, 4+4+1 bytes:
  - Send 0x31323334 (size 10), then 0x35363738 (size 10), then 0x39000000 (size 00).
  - Required: crc_state=0x0376E6E7 and crc_out=0xFC891918 after the third done.
  - Required: exactly 3 done pulses, and busy high 4, 4 and 1 cycles.
- Size equivalence:
  - Send "123456789" as 2-byte words: 0x3132xxxx, 0x3334xxxx, 0x3536xxxx, 0x3738xxxx, each size 01, with nonzero garbage in the low half.
  - Then send 0x39 as size 00.
  - Required: crc_out=0xFC891918.
  - Repeat with size 11 in place of size 10 in the 4+4+1 run; the result must be identical.
- Clear mid-word:
  - Accept 0x31323334 (size 10) and assert clear in the second SHIFT cycle.
  - Required: no done pulse, crc_state=0xFFFFFFFF the next cycle, and in_ready=1.
  - Rerun the check string; the result must be 0xFC891918.
- Clear versus valid collision:
  - In IDLE, assert clear and in_valid together.
  - Required: in_ready=0, word not accepted, busy stays 0, crc_state=INIT.
- Backpressure:
  - Hold in_valid high continuously with changing data.
  - Required: in_ready low for exactly N cycles after each accept.
  - Required: only words present at in_ready=1 edges are folded, checked against a reference model.
